// File: rtl/io_out_fifo.sv
// io_out_fifo: output-side write buffer placed directly after the processor core.
// Every core output write (out_en) is captured with its port address and data word
// into a 2**FDEPTH entry FIFO. Entries drain to an external consumer over a
// valid/ready handshake. Writes that arrive while the FIFO is full (and nothing is
// popped in that cycle) are dropped and flagged in a sticky overflow bit.
// Optional feature macro: IO_OUT_SHADOW_EN adds a per-port "last accepted value"
// shadow output.
module io_out_fifo #(
    parameter  int NUBITS = 32,
    parameter  int NUIOOU = 8,
    parameter  int FDEPTH = 2,
    localparam int AW     = (NUIOOU > 2) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     out_en,
    input  logic [AW-1:0]            addr_out,
    input  logic [NUBITS-1:0]        data_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [AW-1:0]            m_addr,
    output logic [NUBITS-1:0]        m_data,
    output logic [FDEPTH:0]          count,
    output logic                     full,
    output logic                     overflow,
`ifdef IO_OUT_SHADOW_EN
    output logic [NUIOOU*NUBITS-1:0] shadow,
`endif
    input  logic                     ovf_clr
);

    localparam int                EW       = AW + NUBITS;
    localparam int                DEPTH    = 2 ** FDEPTH;
    localparam logic [FDEPTH:0]   CNT_ZERO = (FDEPTH+1)'(0);
    localparam logic [FDEPTH:0]   CNT_ONE  = (FDEPTH+1)'(1);
    localparam logic [FDEPTH:0]   CNT_FULL = (FDEPTH+1)'(DEPTH);
    localparam logic [FDEPTH-1:0] PTR_ZERO = FDEPTH'(0);
    localparam logic [FDEPTH-1:0] PTR_ONE  = FDEPTH'(1);

    logic [EW-1:0]     mem_r [DEPTH];
    logic [FDEPTH-1:0] wr_ptr_r;
    logic [FDEPTH-1:0] rd_ptr_r;
    logic [FDEPTH:0]   count_r;
    logic              ovf_r;

    logic              valid_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [EW-1:0]     head_s;

    // Handshake decode: a pop frees a slot for a same-cycle push, so a full FIFO
    // with a pop in progress still accepts the write.
    always_comb begin
        valid_s = (count_r != CNT_ZERO);
        full_s  = (count_r == CNT_FULL);
        pop_s   = valid_s & m_ready;
        push_s  = out_en & (~full_s | pop_s);
        drop_s  = out_en & full_s & ~pop_s;
        head_s  = mem_r[rd_ptr_r];
    end

    // Storage array write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {addr_out, data_in};
        end
    end

    // Pointers and occupancy; empty/full come from count, never pointer equality.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    // Output drive: head entry is presented only while the FIFO holds data.
    always_comb begin
        m_valid  = valid_s;
        full     = full_s;
        count    = count_r;
        overflow = ovf_r;
        if (valid_s) begin
            m_addr = head_s[EW-1:NUBITS];
            m_data = head_s[NUBITS-1:0];
        end else begin
            m_addr = {AW{1'b0}};
            m_data = {NUBITS{1'b0}};
        end
    end

`ifdef IO_OUT_SHADOW_EN
    logic [NUIOOU*NUBITS-1:0] shadow_r;

    // Per-port record of the last accepted write; dropped writes never land here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= {(NUIOOU*NUBITS){1'b0}};
        end else begin
            for (int p = 0; p < NUIOOU; p++) begin
                if (push_s && (addr_out == AW'(p))) begin
                    shadow_r[p*NUBITS +: NUBITS] <= data_in;
                end
            end
        end
    end

    // Shadow output is the registered per-port record.
    always_comb begin
        shadow = shadow_r;
    end
`endif

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a scoreboard.
module tb_io_out_fifo;

    localparam int NUBITS = 32;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 2;
    localparam int AW     = 3;
    localparam int DEPTH  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 out_en = 1'b0;
    logic [AW-1:0]        addr_out = '0;
    logic [NUBITS-1:0]    data_in = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [AW-1:0]        m_addr;
    logic [NUBITS-1:0]    m_data;
    logic [FDEPTH:0]      count;
    logic                 full;
    logic                 overflow;
    logic                 ovf_clr = 1'b0;
`ifdef IO_OUT_SHADOW_EN
    logic [NUIOOU*NUBITS-1:0] shadow;
    logic [NUBITS-1:0]        sh_m [NUIOOU];
`endif

    io_out_fifo #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out),
        .data_in(data_in), .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_data(m_data), .count(count), .full(full),
        .overflow(overflow),
`ifdef IO_OUT_SHADOW_EN
        .shadow(shadow),
`endif
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, plus sticky flag.
    logic [AW+NUBITS-1:0] mq[$];
    logic                 movf = 1'b0;
    // Scoreboard of entries the consumer should receive, in order.
    logic [AW+NUBITS-1:0] exp_q[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        movf = 1'b0;
`ifdef IO_OUT_SHADOW_EN
        for (int p = 0; p < NUIOOU; p++) sh_m[p] = '0;
`endif
    endtask

    // Drive one cycle of inputs, advance the model for the coming edge, then
    // check the registered state just after that edge.
    task automatic step(input logic en, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                        input logic rdy, input logic clr);
        bit pop, push, drop;
        out_en = en; addr_out = a; data_in = d; m_ready = rdy; ovf_clr = clr;
        pop  = (mq.size() > 0) && rdy;
        push = en && ((mq.size() < DEPTH) || pop);
        drop = en && !push;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back({a, d});
            exp_q.push_back({a, d});
`ifdef IO_OUT_SHADOW_EN
            sh_m[a] = d;
`endif
        end
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
        @(posedge clk);
        #1;
        check("count", 64'(count), 64'(mq.size()));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(movf));
        check("m_valid", 64'(m_valid), 64'(mq.size() != 0));
`ifdef IO_OUT_SHADOW_EN
        for (int p = 0; p < NUIOOU; p++)
            check("shadow", 64'(shadow[p*NUBITS +: NUBITS]), 64'(sh_m[p]));
`endif
    endtask

    // Monitor: consume the scoreboard whenever the DUT completes a handshake.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 64'(m_data), 64'hDEAD);
            end else begin
                check("m_addr", 64'(m_addr), 64'(exp_q[0][AW+NUBITS-1:NUBITS]));
                check("m_data", 64'(m_data), 64'(exp_q[0][NUBITS-1:0]));
                void'(exp_q.pop_front());
            end
        end else if (!m_valid) begin
            check("empty_gate", 64'({m_addr, m_data}), 64'h0);
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check("rst_valid", 64'(m_valid), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_full", 64'(full), 64'h0);
        check("rst_ovf", 64'(overflow), 64'h0);
        check("rst_data", 64'(m_data), 64'h0);
        check("rst_addr", 64'(m_addr), 64'h0);
        rst = 1'b1;

        // Single write then one-cycle pop.
        step(1'b1, 3'd3, 32'h0000_00AA, 1'b0, 1'b0);
        check("single_addr", 64'(m_addr), 64'h3);
        check("single_data", 64'(m_data), 64'hAA);
        step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        check("single_drained", 64'(count), 64'h0);

        // Fill past capacity: fifth write dropped, then drain in order.
        for (int i = 1; i <= 5; i++) step(1'b1, 3'(i), 32'(i), 1'b0, 1'b0);
        check("fill_ovf", 64'(overflow), 64'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Full with simultaneous pop and push: no drop.
        step(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, 3'd1, 32'(16 + i), 1'b0, 1'b0);
        step(1'b1, 3'd7, 32'd9, 1'b1, 1'b0);
        check("pushpop_count", 64'(count), 64'h4);
        check("pushpop_ovf", 64'(overflow), 64'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        check("pushpop_empty", 64'(exp_q.size()), 64'h0);

        // Drop and clear together: set wins; clear alone then clears.
        for (int i = 0; i < 4; i++) step(1'b1, 3'd2, 32'(40 + i), 1'b0, 1'b0);
        step(1'b1, 3'd2, 32'd99, 1'b0, 1'b1);
        check("set_wins", 64'(overflow), 64'h1);
        step(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
        check("clr_alone", 64'(overflow), 64'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 32'(60 + i), 1'b0, 1'b0);
        out_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_valid", 64'(m_valid), 64'h0);
        check("async_count", 64'(count), 64'h0);
        model_reset();
        #3 rst = 1'b1;
        step(1'b1, 3'd5, 32'h55, 1'b0, 1'b0);
        check("post_rst_data", 64'(m_data), 64'h55);
        step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), 32'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_out_fifo.md
Name: io_out_fifo

Overview:
- Output-side stage directly downstream of the processor core.
- Captures every output-port write, i.e. each cycle the core asserts out_en, together with its port address and data word.
- Buffers those writes in a small FIFO so the core never stalls.
- Drains them to an external consumer through a valid/ready handshake, and flags writes lost to overflow.

Parameters:
- NUBITS, 32, data word width; matches the core data width.
- NUIOOU, 8, number of output port addresses; address width is $clog2(NUIOOU), minimum 1 bit.
- FDEPTH, 2, log2 of FIFO depth; depth = 2**FDEPTH entries.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- out_en  input  1  core output write strobe, one-cycle pulse per write.
- addr_out  input  $clog2(NUIOOU)  port address for the current write.
- data_in  input  NUBITS  data word for the current write; driven from core data_out.
- m_valid  output  1  head entry available.
- m_ready  input  1  consumer accepts the head entry.
- m_addr  output  $clog2(NUIOOU)  port address of the head entry.
- m_data  output  NUBITS  data of the head entry.
- count  output  FDEPTH+1  number of entries stored.
- full  output  1  count == 2**FDEPTH.
- overflow  output  1  sticky flag: at least one write was dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - m_valid = 0, full = 0, overflow = 0.
  - m_addr and m_data = 0.
  - Storage array contents are not reset.
- Push: at a clk edge where out_en = 1 and a slot is free, store {addr_out, data_in} at wr_ptr; wr_ptr increments modulo 2**FDEPTH.
- Pop: at a clk edge where m_valid = 1 and m_ready = 1, rd_ptr increments modulo 2**FDEPTH.
- A slot is free when full = 0, or when a pop occurs in the same cycle. A full FIFO with a simultaneous pop accepts the push, and count stays at 2**FDEPTH.
- count tracks the queue:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop or on neither.
- Latency:
  - A write pushed at edge k drives m_valid = 1 from just after edge k, with m_addr/m_data equal to the written values.
  - No same-cycle bypass: an empty FIFO presents nothing in the cycle out_en is high.
- Outputs:
  - m_valid = (count != 0).
  - m_addr and m_data are combinational reads of entry rd_ptr, gated to 0 when empty.
  - full and count are registered or derived combinationally from registered state; outputs never glitch on inputs other than m_ready.
- Drop:
  - out_en = 1 while full = 1 and no pop in the same cycle: the write is discarded and FIFO state is unchanged.
  - overflow is set at that edge.
- overflow clear:
  - ovf_clr = 1 clears overflow at the edge.
  - If a drop occurs in the same cycle, set wins and overflow = 1.
- Handshake rules:
  - The consumer may hold m_ready high continuously.
  - m_addr/m_data stay stable while m_valid = 1 and m_ready = 0.
  - out_en while empty with m_ready = 1 pushes only; no pop occurs that cycle.
- Pointer wrap: pointers are FDEPTH bits and wrap naturally. Full/empty are resolved by count, never by pointer equality alone.
- Reset mid-operation: all queued entries are discarded and m_valid drops immediately (asynchronous).

Optional Feature:
- Macro: IO_OUT_SHADOW_EN.
- When defined:
  - Adds output port shadow, width NUIOOU*NUBITS.
  - Slice [p*NUBITS +: NUBITS] holds the last data value accepted (pushed, not dropped) for port address p.
  - The slice updates at the push edge.
  - All slices reset to 0.
  - Dropped writes do not update the shadow.
- When not defined: port shadow and its registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle → m_valid=0, count=0, full=0, overflow=0, m_data=0, m_addr=0.
- Push (addr 3, 0x0000_00AA), m_ready=0 → the next cycle m_valid=1, m_addr=3, m_data=0xAA, count=1. Raise m_ready for one cycle → count=0, m_valid=0.
- FDEPTH=2, m_ready=0, push 5 writes with data 1..5 → count=4, full=1 after the 4th write. 5th write dropped, overflow=1. Drain with m_ready=1 → data order 1,2,3,4, then m_valid=0.
- Full FIFO with m_ready=1 and out_en=1 (data 9) in the same cycle → no drop, overflow unchanged, count stays 4. After draining, the last word is 9.
- Drop and ovf_clr in the same cycle → overflow=1. Next cycle, ovf_clr alone → overflow=0.
- rst pulsed low while count=3 → m_valid=0 and count=0 immediately. After release, a push of 0x55 is the first word out.
